// File: rtl/mem_pattern_if.sv
// Memory request bus between the pattern tester (master) and the data memory (slave).
interface mem_pattern_if;
  logic        mem_stall;
  logic [31:0] dmem_data_out;
  logic        dmem_read_in;
  logic        dmem_write_in;
  logic [29:0] dmem_addr;
  logic [31:0] data_from_reg;
  logic [3:0]  dc_byte_w_en;

  modport master (
    input  mem_stall, dmem_data_out,
    output dmem_read_in, dmem_write_in, dmem_addr, data_from_reg, dc_byte_w_en
  );

  modport slave (
    output mem_stall, dmem_data_out,
    input  dmem_read_in, dmem_write_in, dmem_addr, data_from_reg, dc_byte_w_en
  );
endinterface

// File: rtl/mem_pattern_tester.sv
// Walking-ones memory tester: writes 1<<i to NUM_WORDS strided words, reads them back, counts mismatches.
// Optional stall watchdog and timeout output enabled by defining MEM_TEST_TIMEOUT_EN.
module mem_pattern_tester #(
  parameter logic [29:0] ADDR_BASE   = 30'h1000,
  parameter int          NUM_WORDS   = 8,
  parameter logic [29:0] ADDR_STRIDE = 30'd32
) (
  input  logic                ui_clk,
  input  logic                rst,
  input  logic                start,
  mem_pattern_if.master       mem,
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic [7:0]          err_count,
  output logic [29:0]         first_err_addr,
  output logic [7:0]          led
`ifdef MEM_TEST_TIMEOUT_EN
  ,
  output logic                timeout
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  idx;
  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic        launch, complete, last_word, mismatch;
  logic        to_hit, timeout_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] rot_left(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

  assign launch    = ((state == IDLE) || (state == DONE)) && start;
  assign complete  = ((state == WRITE) || (state == READ)) && !mem.mem_stall;
  assign last_word = (idx == 8'(NUM_WORDS - 1));
  assign mismatch  = (state == READ) && complete && (mem.dmem_data_out != data_q);

  assign mem.dmem_addr     = addr_q;
  assign mem.data_from_reg = data_q;
  assign mem.dc_byte_w_en  = 4'b1111;

`ifdef MEM_TEST_TIMEOUT_EN
  logic [15:0] stall_cnt;

  // Watchdog fires on the stalled edge that brings the counter to 16'hFFFF.
  assign to_hit  = busy && mem.mem_stall && (stall_cnt == 16'hFFFE);
  assign timeout = timeout_q;

  always_ff @(posedge ui_clk) begin
    if (rst) begin
      stall_cnt <= 16'h0;
      timeout_q <= 1'b0;
    end else if (launch) begin
      stall_cnt <= 16'h0;
      timeout_q <= 1'b0;
    end else if (complete) begin
      stall_cnt <= 16'h0;
    end else if (busy && mem.mem_stall) begin
      stall_cnt <= stall_cnt + 16'd1;
      if (to_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign timeout_q = 1'b0;
`endif

  always_ff @(posedge ui_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    mem.dmem_read_in  = 1'b1;
    mem.dmem_write_in = 1'b1;
    busy              = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = WRITE;
      end
      WRITE: begin
        mem.dmem_read_in = 1'b0;
        busy             = 1'b1;
        if (to_hit)                     state_nxt = DONE;
        else if (complete && last_word) state_nxt = READ;
      end
      READ: begin
        mem.dmem_write_in = 1'b0;
        busy              = 1'b1;
        if (to_hit)                     state_nxt = DONE;
        else if (complete && last_word) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pass = (state == DONE) && (err_count == 8'd0) && !timeout_q;
  assign fail = (state == DONE) && !pass;

  // Index, address and pattern advance together; all hold while the memory stalls.
  always_ff @(posedge ui_clk) begin
    if (rst) begin
      idx            <= 8'd0;
      addr_q         <= ADDR_BASE;
      data_q         <= 32'h0;
      err_count      <= 8'd0;
      first_err_addr <= 30'h0;
      led            <= 8'h0;
    end else if (launch) begin
      idx            <= 8'd0;
      addr_q         <= ADDR_BASE;
      data_q         <= 32'h1;
      err_count      <= 8'd0;
      first_err_addr <= 30'h0;
    end else if (complete) begin
      if (last_word) begin
        idx    <= 8'd0;
        addr_q <= ADDR_BASE;
        data_q <= 32'h1;
      end else begin
        idx    <= idx + 8'd1;
        addr_q <= addr_q + ADDR_STRIDE;
        data_q <= rot_left(data_q);
      end
      if (state == READ) led <= mem.dmem_data_out[7:0];
      if (mismatch) begin
        err_count <= sat_inc(err_count);
        if (err_count == 8'd0) first_err_addr <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Directed bench for mem_pattern_tester: 8-word instance with stalling memory model, 40-word instance for error accumulation.
module tb_mem_pattern_tester;

  logic ui_clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 ui_clk = ~ui_clk;

  mem_pattern_if bus_a();
  mem_pattern_if bus_b();

  logic        busy_a, pass_a, fail_a, busy_b, pass_b, fail_b;
  logic [7:0]  err_a, led_a, err_b, led_b;
  logic [29:0] ferr_a, ferr_b;
`ifdef MEM_TEST_TIMEOUT_EN
  logic        to_a, to_b;
`endif

  mem_pattern_tester dut_a (
    .ui_clk(ui_clk), .rst(rst), .start(start_a), .mem(bus_a.master),
    .busy(busy_a), .pass(pass_a), .fail(fail_a), .err_count(err_a),
    .first_err_addr(ferr_a), .led(led_a)
`ifdef MEM_TEST_TIMEOUT_EN
    , .timeout(to_a)
`endif
  );

  mem_pattern_tester #(.NUM_WORDS(40)) dut_b (
    .ui_clk(ui_clk), .rst(rst), .start(start_b), .mem(bus_b.master),
    .busy(busy_b), .pass(pass_b), .fail(fail_b), .err_count(err_b),
    .first_err_addr(ferr_b), .led(led_b)
`ifdef MEM_TEST_TIMEOUT_EN
    , .timeout(to_b)
`endif
  );

  // Memory model A: optional 3-cycle stall per request, optional single corrupted word.
  logic        stall_en_a = 1'b0, stall_force_a = 1'b0, corrupt_on_a = 1'b0;
  logic [29:0] corrupt_a = 30'h0, off_a;
  int          scnt_a = 0;
  logic [31:0] mem_a [0:63];
  logic [29:0] wlog_addr_a [$];
  logic [31:0] wlog_data_a [$];

  always_comb off_a = bus_a.dmem_addr - 30'h1000;
  always_comb bus_a.mem_stall = stall_force_a | (stall_en_a & (scnt_a < 3));
  always_comb begin
    bus_a.dmem_data_out = 32'h0;
    if (!(corrupt_on_a && bus_a.dmem_addr == corrupt_a))
      bus_a.dmem_data_out = mem_a[off_a[10:5]];
  end

  always @(posedge ui_clk) begin
    if (rst || !(bus_a.dmem_read_in ^ bus_a.dmem_write_in) || !bus_a.mem_stall) scnt_a <= 0;
    else scnt_a <= scnt_a + 1;
    if (!rst && !bus_a.dmem_read_in && bus_a.dmem_write_in && !bus_a.mem_stall) begin
      mem_a[off_a[10:5]] <= bus_a.data_from_reg;
      wlog_addr_a.push_back(bus_a.dmem_addr);
      wlog_data_a.push_back(bus_a.data_from_reg);
    end
  end

  // Memory model B: never stalls, every read returns zero.
  logic [29:0] wlog_addr_b [$];
  logic [31:0] wlog_data_b [$];
  always_comb bus_b.mem_stall = 1'b0;
  always_comb bus_b.dmem_data_out = 32'h0;
  always @(posedge ui_clk) begin
    if (!rst && !bus_b.dmem_read_in && bus_b.dmem_write_in && !bus_b.mem_stall) begin
      wlog_addr_b.push_back(bus_b.dmem_addr);
      wlog_data_b.push_back(bus_b.data_from_reg);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  task automatic run_a(input int bound, output int cycles, output logic busy_seen);
    @(negedge ui_clk) start_a = 1'b1;
    @(posedge ui_clk); #1;
    start_a   = 1'b0;
    cycles    = 1;
    busy_seen = busy_a;
    while (!(pass_a || fail_a) && cycles < bound) begin
      @(posedge ui_clk); #1;
      cycles++;
    end
    if (!(pass_a || fail_a)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_a_done: no DONE within %0d cycles, required DONE", bound);
    end
  endtask

  typedef struct {
    logic        stall;
    int          corrupt;
    logic        exp_pass;
    logic        exp_fail;
    logic [7:0]  exp_err;
    logic [29:0] exp_first;
    logic [7:0]  exp_led;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          cyc, base, k;
    logic        bsy;
    string       tag;

    vecs[0] = '{1'b1, -1, 1'b1, 1'b0, 8'd0, 30'h0,    8'h80, 65};
    vecs[1] = '{1'b1,  2, 1'b0, 1'b1, 8'd1, 30'h1040, 8'h80, 65};
    vecs[2] = '{1'b0, -1, 1'b1, 1'b0, 8'd0, 30'h0,    8'h80, 17};
    vecs[3] = '{1'b0,  7, 1'b0, 1'b1, 8'd1, 30'h10E0, 8'h00, 17};
    vecs[4] = '{1'b0,  0, 1'b0, 1'b1, 8'd1, 30'h1000, 8'h80, 17};

    // Reset state
    repeat (3) @(posedge ui_clk);
    @(negedge ui_clk) rst = 1'b0;
    chk("rst_strobes", {30'h0, bus_a.dmem_read_in, bus_a.dmem_write_in}, 32'h3);
    chk("rst_addr", {2'b0, bus_a.dmem_addr}, 32'h1000);
    chk("rst_data", bus_a.data_from_reg, 32'h0);
    chk("rst_bytes", {28'h0, bus_a.dc_byte_w_en}, 32'hF);
    chk("rst_status", {29'h0, busy_a, pass_a, fail_a}, 32'h0);
    chk("rst_err", {24'h0, err_a}, 32'h0);
    chk("rst_ferr", {2'b0, ferr_a}, 32'h0);
    chk("rst_led", {24'h0, led_a}, 32'h0);

    for (int i = 0; i < 5; i++) begin
      @(negedge ui_clk);
      stall_en_a   = vecs[i].stall;
      corrupt_on_a = (vecs[i].corrupt >= 0);
      corrupt_a    = 30'h1000 + 30'(vecs[i].corrupt * 32);
      base         = wlog_addr_a.size();
      run_a(2000, cyc, bsy);
      tag = $sformatf("v%0d", i);
      chk({tag, "_busy_run"}, {31'h0, bsy}, 32'h1);
      chk({tag, "_cycles"}, cyc, vecs[i].exp_cyc);
      chk({tag, "_pass"}, {31'h0, pass_a}, {31'h0, vecs[i].exp_pass});
      chk({tag, "_fail"}, {31'h0, fail_a}, {31'h0, vecs[i].exp_fail});
      chk({tag, "_busy_done"}, {31'h0, busy_a}, 32'h0);
      chk({tag, "_err"}, {24'h0, err_a}, {24'h0, vecs[i].exp_err});
      chk({tag, "_ferr"}, {2'b0, ferr_a}, {2'b0, vecs[i].exp_first});
      chk({tag, "_led"}, {24'h0, led_a}, {24'h0, vecs[i].exp_led});
      chk({tag, "_nwrites"}, wlog_addr_a.size() - base, 8);
      for (k = 0; k < 8 && base + k < wlog_addr_a.size(); k++) begin
        chk($sformatf("%s_waddr%0d", tag, k), {2'b0, wlog_addr_a[base + k]}, 32'h1000 + 32'(k * 32));
        chk($sformatf("%s_wdata%0d", tag, k), wlog_data_a[base + k], 32'h1 << k);
      end
    end

    // Start while busy is ignored; reset during READ of word 5 aborts to IDLE.
    @(negedge ui_clk);
    stall_en_a   = 1'b1;
    corrupt_on_a = 1'b0;
    start_a      = 1'b1;
    @(negedge ui_clk) start_a = 1'b0;
    k = 0;
    while (!(bus_a.dmem_addr == 30'h1060 && !bus_a.dmem_read_in && bus_a.dmem_write_in) && k < 200) begin
      @(negedge ui_clk);
      k++;
    end
    chk("seq_reach_w3", {31'h0, (k < 200)}, 32'h1);
    start_a = 1'b1;
    @(negedge ui_clk) start_a = 1'b0;
    chk("ign_addr", {2'b0, bus_a.dmem_addr}, 32'h1060);
    chk("ign_busy", {31'h0, busy_a}, 32'h1);
    chk("ign_strobes", {30'h0, bus_a.dmem_read_in, bus_a.dmem_write_in}, 32'h1);
    k = 0;
    while (!(bus_a.dmem_addr == 30'h10A0 && bus_a.dmem_read_in && !bus_a.dmem_write_in) && k < 400) begin
      @(negedge ui_clk);
      k++;
    end
    chk("seq_reach_r5", {31'h0, (k < 400)}, 32'h1);
    chk("pre_rst_led", {24'h0, led_a}, 32'h10);
    rst = 1'b1;
    @(negedge ui_clk);
    chk("abort_strobes", {30'h0, bus_a.dmem_read_in, bus_a.dmem_write_in}, 32'h3);
    chk("abort_busy", {31'h0, busy_a}, 32'h0);
    chk("abort_addr", {2'b0, bus_a.dmem_addr}, 32'h1000);
    chk("abort_data", bus_a.data_from_reg, 32'h0);
    chk("abort_led", {24'h0, led_a}, 32'h0);
    chk("abort_passfail", {30'h0, pass_a, fail_a}, 32'h0);
    rst = 1'b0;
    @(negedge ui_clk);
    chk("abort_stays_idle", {31'h0, busy_a}, 32'h0);

    // 40-word pass against all-zero reads.
    base = wlog_addr_b.size();
    start_b = 1'b1;
    @(posedge ui_clk); #1;
    start_b = 1'b0;
    cyc = 1;
    while (!(pass_b || fail_b) && cyc < 2000) begin
      @(posedge ui_clk); #1;
      cyc++;
    end
    chk("b_cycles", cyc, 81);
    chk("b_err", {24'h0, err_b}, 32'd40);
    chk("b_fail", {30'h0, pass_b, fail_b}, 32'h1);
    chk("b_ferr", {2'b0, ferr_b}, 32'h1000);
    chk("b_led", {24'h0, led_b}, 32'h0);
    chk("b_nwrites", wlog_addr_b.size() - base, 40);
    if (wlog_addr_b.size() >= base + 40) begin
      chk("b_waddr33", {2'b0, wlog_addr_b[base + 33]}, 32'h1420);
      chk("b_wdata33", wlog_data_b[base + 33], 32'h2);
      chk("b_wdata39", wlog_data_b[base + 39], 32'h80);
    end

`ifdef MEM_TEST_TIMEOUT_EN
    chk("to_clear_before", {31'h0, to_a}, 32'h0);
    @(negedge ui_clk);
    stall_en_a    = 1'b0;
    stall_force_a = 1'b1;
    run_a(70000, cyc, bsy);
    chk("to_cycles", cyc, 65536);
    chk("to_flag", {31'h0, to_a}, 32'h1);
    chk("to_passfail", {30'h0, pass_a, fail_a}, 32'h1);
    chk("to_busy", {31'h0, busy_a}, 32'h0);
    stall_force_a = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
